// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the trapezoidal membership sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, widths, cfg-word field offsets, one divider step helper.
package fuzzy_pkg;

    localparam int W          = 8;
    localparam int MU_MAX     = 255;
    localparam int DIV_CYCLES = 16;

    // One set occupies a 32-bit cfg word laid out as {A,B,C,D}, A in the MSB byte.
    localparam int CFG_WORD_W = 4 * W;
    localparam int OFF_A      = 3 * W;
    localparam int OFF_B      = 2 * W;
    localparam int OFF_C      = 1 * W;
    localparam int OFF_D      = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLASSIFY,
        ST_DIVIDE,
        ST_STORE,
        ST_DONE
    } trap_state_t;

    // One restoring-division step: returns {remainder[7:0], quotient[15:0]}.
    // The remainder always stays below the divisor (<=255), so the 8-bit modular
    // subtraction of the low byte yields the exact remainder even when the
    // shifted value carries into bit 8.
    function automatic logic [23:0] div_step(input logic [7:0]  rem,
                                             input logic [15:0] quo,
                                             input logic [7:0]  dvs);
        logic [8:0] sh;
        sh = {rem, quo[15]};
        if (sh >= {1'b0, dvs}) begin
            div_step = {sh[7:0] - dvs, quo[14:0], 1'b1};
        end else begin
            div_step = {sh[7:0], quo[14:0], 1'b0};
        end
    endfunction

endpackage

// File: rtl/trap_membership_seq_if.sv
// Request/response bundle between the input-sampling stage and the sequencer.
// Latency: n/a (wires only).
// Backpressure: none; start is dropped by the slave while busy or done.
// master drives start/x/cfg and receives busy/done/mu; slave is the sequencer side.
interface trap_membership_seq_if #(
    parameter int N_SETS = 4,
    parameter int W      = 8
) ();
    logic                  start;
    logic [W-1:0]          x;
    logic [N_SETS*4*W-1:0] cfg;
    logic                  busy;
    logic                  done;
    logic [N_SETS*W-1:0]   mu;

    modport master (output start, x, cfg, input  busy, done, mu);
    modport slave  (input  start, x, cfg, output busy, done, mu);
endinterface

// File: rtl/trap_div_serial.sv
// 16/8 unsigned restoring divider, one quotient bit per clock.
// Latency: ready pulses exactly DIV_CYCLES cycles after the load cycle.
// Backpressure: none; a new load restarts the division, quotient holds after ready.
// Ports: clk, rst (async, active-high), load_i, dividend_i[15:0], divisor_i[7:0],
//        quotient_o[15:0], ready_o.
module trap_div_serial
    import fuzzy_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [15:0] dividend_i,
    input  logic [7:0]  divisor_i,
    output logic [15:0] quotient_o,
    output logic        ready_o
);

    logic [7:0]  rem_q;
    logic [15:0] quo_q;
    logic [7:0]  dvs_q;
    logic [4:0]  cnt_q;
    logic        run_q;
    logic        ready_q;

    // The load cycle already performs the first step, so 15 further steps
    // complete the quotient and ready lands DIV_CYCLES cycles after load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            ready_q <= 1'b0;
        end else if (load_i) begin
            {rem_q, quo_q} <= div_step(8'd0, dividend_i, divisor_i);
            dvs_q          <= divisor_i;
            cnt_q          <= 5'd1;
            run_q          <= 1'b1;
            ready_q        <= 1'b0;
        end else if (run_q) begin
            {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
            cnt_q          <= cnt_q + 5'd1;
            run_q          <= (cnt_q != 5'(DIV_CYCLES - 1));
            ready_q        <= (cnt_q == 5'(DIV_CYCLES - 1));
        end else begin
            ready_q <= 1'b0;
        end
    end

    assign quotient_o = quo_q;
    assign ready_o    = ready_q;

endmodule

// File: rtl/trap_membership_seq.sv
// Evaluates trapezoidal membership of one crisp x against N_SETS sets, one shared divider.
// Latency: done at cycle 1 + sum(2 per flat set, 18 per slope set) after the accept edge.
// Backpressure: none; start is only sampled in IDLE, extra starts are dropped, not queued.
// Ports: clk, rst (async, active-high), bus (slave: start/x/cfg in, busy/done/mu out).
module trap_membership_seq
    import fuzzy_pkg::*;
#(
    parameter int N_SETS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    trap_membership_seq_if.slave bus
);

    localparam int IDX_W = (N_SETS > 1) ? $clog2(N_SETS) : 1;

    trap_state_t             state_q, state_d;
    logic [IDX_W-1:0]        idx_q;
    logic [W-1:0]            x_q;
    logic [CFG_WORD_W-1:0]   cfg_q [N_SETS];
    logic [W-1:0]            mu_q  [N_SETS];
    logic [W-1:0]            res_q;

    logic [CFG_WORD_W-1:0]   cur_word;
    logic [W-1:0]            bp_a, bp_b, bp_c, bp_d;
    logic [W-1:0]            span_num;
    logic                    cls_trivial;
    logic [W-1:0]            cls_res;
    logic [15:0]             div_dividend;
    logic [W-1:0]            div_divisor;
    logic                    div_load;
    logic [15:0]             div_quotient;
    logic                    div_ready;
    logic [W-1:0]            div_res;
    logic                    last_set;

    // ---------------- classification of the current set ----------------
    // The plateau test runs first so shoulder-shaped sets (A=B or C=D) read
    // full membership at the shared breakpoint. Slopes are only reached with
    // A<X<B or C<X<D, so the divisor is never zero even for malformed sets.
    always_comb begin
        cur_word     = cfg_q[idx_q];
        bp_a         = cur_word[OFF_A +: W];
        bp_b         = cur_word[OFF_B +: W];
        bp_c         = cur_word[OFF_C +: W];
        bp_d         = cur_word[OFF_D +: W];
        cls_trivial  = 1'b1;
        cls_res      = '0;
        span_num     = '0;
        div_dividend = '0;
        div_divisor  = '0;
        if (x_q >= bp_b && x_q <= bp_c) begin
            cls_res = W'(MU_MAX);
        end else if (x_q <= bp_a || x_q >= bp_d) begin
            cls_res = '0;
        end else if (x_q < bp_b) begin
            cls_trivial  = 1'b0;
            span_num     = x_q - bp_a;
            div_dividend = {8'd0, span_num} * 16'(MU_MAX);
            div_divisor  = bp_b - bp_a;
        end else begin
            cls_trivial  = 1'b0;
            span_num     = bp_d - x_q;
            div_dividend = {8'd0, span_num} * 16'(MU_MAX);
            div_divisor  = bp_d - bp_c;
        end
    end

    // Quotient is below 255 whenever numerator < denominator; the clamp only
    // guards against an impossible overflow rather than wrapping silently.
    assign div_res  = (|div_quotient[15:8]) ? W'(MU_MAX) : div_quotient[7:0];
    assign last_set = (idx_q == IDX_W'(N_SETS - 1));

    trap_div_serial u_div (
        .clk        (clk),
        .rst        (rst),
        .load_i     (div_load),
        .dividend_i (div_dividend),
        .divisor_i  (div_divisor),
        .quotient_o (div_quotient),
        .ready_o    (div_ready)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (bus.start) state_d = ST_CLASSIFY;
            ST_CLASSIFY: state_d = cls_trivial ? ST_STORE : ST_DIVIDE;
            ST_DIVIDE:   if (div_ready) state_d = ST_STORE;
            ST_STORE:    state_d = last_set ? ST_DONE : ST_CLASSIFY;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        div_load = 1'b0;
        case (state_q)
            ST_CLASSIFY: begin
                bus.busy = 1'b1;
                div_load = !cls_trivial;
            end
            ST_DIVIDE:   bus.busy = 1'b1;
            ST_STORE:    bus.busy = 1'b1;
            ST_DONE:     bus.done = 1'b1;
            default:     ;
        endcase
    end

    // ---------------- datapath registers ----------------
    // x and cfg are snapshotted at accept so the whole run sees one request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q   <= '0;
            idx_q <= '0;
            res_q <= '0;
            for (int i = 0; i < N_SETS; i++) begin
                cfg_q[i] <= '0;
                mu_q[i]  <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        x_q   <= bus.x;
                        idx_q <= '0;
                        for (int i = 0; i < N_SETS; i++) begin
                            cfg_q[i] <= bus.cfg[i*CFG_WORD_W +: CFG_WORD_W];
                        end
                    end
                end
                ST_CLASSIFY: if (cls_trivial) res_q <= cls_res;
                ST_DIVIDE:   if (div_ready) res_q <= div_res;
                ST_STORE: begin
                    mu_q[idx_q] <= res_q;
                    if (!last_set) idx_q <= idx_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < N_SETS; g++) begin : g_mu
        assign bus.mu[g*W +: W] = mu_q[g];
    end

endmodule

// File: tb/tb_trap_membership_seq.sv
// Directed bench for trap_membership_seq with a per-cycle reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_trap_membership_seq;

    logic clk;
    logic rst;

    trap_membership_seq_if #(.N_SETS(4), .W(8)) bif ();

    trap_membership_seq #(.N_SETS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the outputs must be, derived from the
    // membership rules and per-set cycle costs.
    bit          m_active = 1'b0;
    int          m_cyc    = 0;
    int          m_total  = 0;
    logic [31:0] m_mu     = '0;
    logic [31:0] m_pend   = '0;

    function automatic int ref_mu(input int xv, input int a, input int b,
                                  input int c, input int d);
        if (xv >= b && xv <= c) return 255;
        if (xv <= a || xv >= d) return 0;
        if (xv < b) return ((xv - a) * 255) / (b - a);
        return ((d - xv) * 255) / (d - c);
    endfunction

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {8'(a), 8'(b), 8'(c), 8'(d)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    task automatic model_edge();
        logic [31:0] w;
        int a, b, c, d, v;
        if (rst) begin
            m_active = 1'b0;
            m_mu     = '0;
        end else if (m_active) begin
            if (m_cyc == m_total) begin
                m_active = 1'b0;
            end else begin
                m_cyc++;
                if (m_cyc == m_total) m_mu = m_pend;
            end
        end else if (bif.start) begin
            m_active = 1'b1;
            m_cyc    = 1;
            m_total  = 1;
            for (int i = 0; i < 4; i++) begin
                w = bif.cfg[i*32 +: 32];
                a = int'(w[31:24]);
                b = int'(w[23:16]);
                c = int'(w[15:8]);
                d = int'(w[7:0]);
                v = ref_mu(int'(bif.x), a, b, c, d);
                m_pend[i*8 +: 8] = 8'(v);
                if ((int'(bif.x) >= b && int'(bif.x) <= c) ||
                    int'(bif.x) <= a || int'(bif.x) >= d)
                    m_total += 2;
                else
                    m_total += 18;
            end
        end
    endtask

    task automatic compare_cycle();
        chk("busy", bif.busy, 64'(m_active && m_cyc < m_total));
        chk("done", bif.done, 64'(m_active && m_cyc == m_total));
        if (!m_active || m_cyc == m_total) chk("mu", bif.mu, m_mu);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_cycle();
    endtask

    // Issues one request; returns the done cycle, or -1 if none within budget.
    task automatic run_req(input logic [7:0] xv, input logic [127:0] cv,
                           input int inj1, input int inj2, input int rst_at,
                           input bit chg, output int lat);
        int c;
        lat       = -1;
        bif.x     = xv;
        bif.cfg   = cv;
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        c = 1;
        while (c < 150) begin
            if (bif.done) begin
                lat = c;
                break;
            end
            if (chg && c == 1) begin
                bif.x   = ~xv;
                bif.cfg = ~cv;
            end
            if (c == inj1 || c == inj2) begin
                bif.start = 1'b1;
                bif.x     = xv + 8'd10;
            end else begin
                bif.start = 1'b0;
            end
            if (c == rst_at) begin
                rst      = 1'b1;
                m_active = 1'b0;
                m_mu     = '0;
            end else if (rst_at >= 0 && c == rst_at + 1) begin
                rst = 1'b0;
            end
            tick();
            c++;
        end
        bif.start = 1'b0;
        if (lat >= 0) tick();
    endtask

    logic [127:0] cfg_a, cfg_m, cfg_g, cfg_b, cfg_w;
    int lat;

    initial begin
        cfg_a = {4{pk(10, 20, 30, 40)}};
        cfg_m = {pk(0, 5, 20, 30), pk(30, 40, 50, 60), pk(10, 20, 30, 40), pk(10, 20, 30, 40)};
        cfg_g = {4{pk(50, 50, 60, 60)}};
        cfg_b = {4{pk(30, 20, 10, 40)}};
        cfg_w = {4{pk(0, 100, 150, 250)}};

        rst       = 1'b1;
        bif.start = 1'b0;
        bif.x     = '0;
        bif.cfg   = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", bif.busy, 0);
        chk("rst_done", bif.done, 0);
        chk("rst_mu", bif.mu, 0);
        tick();

        // Basic membership, first-slot values and latency.
        run_req(8'd15, cfg_a, -1, -1, -1, 1'b0, lat);
        chk("lat_x15", lat, 73);
        chk("mu0_x15", bif.mu[7:0], 127);
        run_req(8'd25, cfg_a, -1, -1, -1, 1'b0, lat);
        chk("lat_x25", lat, 9);
        chk("mu0_x25", bif.mu[7:0], 255);
        run_req(8'd35, cfg_a, -1, -1, -1, 1'b0, lat);
        chk("mu0_x35", bif.mu[7:0], 127);
        run_req(8'd5, cfg_a, -1, -1, -1, 1'b0, lat);
        chk("mu0_x5", bif.mu[7:0], 0);
        run_req(8'd40, cfg_a, -1, -1, -1, 1'b0, lat);
        chk("mu0_x40", bif.mu[7:0], 0);

        // Mixed regions: two slopes, one outside, one plateau.
        run_req(8'd15, cfg_m, -1, -1, -1, 1'b0, lat);
        chk("lat_mixed", lat, 41);
        chk("mu_mixed", bif.mu, 32'hFF00_7F7F);

        // Degenerate shoulders and a malformed set.
        run_req(8'd50, cfg_g, -1, -1, -1, 1'b0, lat);
        chk("mu0_deg50", bif.mu[7:0], 255);
        run_req(8'd60, cfg_g, -1, -1, -1, 1'b0, lat);
        chk("mu0_deg60", bif.mu[7:0], 255);
        run_req(8'd49, cfg_g, -1, -1, -1, 1'b0, lat);
        chk("mu0_deg49", bif.mu[7:0], 0);
        run_req(8'd25, cfg_b, -1, -1, -1, 1'b0, lat);
        chk("lat_malformed", lat, 9);
        chk("mu0_malformed", bif.mu[7:0], 0);

        // Starts while busy are dropped.
        run_req(8'd15, cfg_a, 3, 20, -1, 1'b0, lat);
        chk("lat_ignored_start", lat, 73);
        chk("mu_ignored_start", bif.mu, {4{8'd127}});
        repeat (5) tick();

        // Reset mid-run: no done, outputs cleared.
        run_req(8'd15, cfg_a, -1, -1, 10, 1'b0, lat);
        chk("no_done_after_rst", lat, 64'(-1));
        chk("mu_after_rst", bif.mu, 0);
        chk("busy_after_rst", bif.busy, 0);

        // Fresh run after reset.
        run_req(8'd40, cfg_w, -1, -1, -1, 1'b0, lat);
        chk("lat_fresh", lat, 73);
        chk("mu0_fresh", bif.mu[7:0], 102);

        // Inputs changed right after accept must not matter.
        run_req(8'd180, cfg_w, -1, -1, -1, 1'b1, lat);
        chk("lat_latched", lat, 73);
        chk("mu_latched", bif.mu, {4{8'd178}});
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
